// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU command front-end.
// Holds the opcode and loader-state enumerations, default payload/opcode
// widths, default memory depths and a helper that derives the address width.
package tpu_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_OPC_W     = 3;
  localparam int DEF_W_DEPTH   = 4;
  localparam int DEF_INP_DEPTH = 4;
  localparam int DEF_INS_DEPTH = 8;

  typedef enum logic [2:0] {
    OPC_NOP      = 3'b000,
    OPC_LOAD_W   = 3'b001,
    OPC_LOAD_INP = 3'b010,
    OPC_LOAD_INS = 3'b011,
    OPC_START    = 3'b101,
    OPC_ABORT    = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_W   = 3'd1,
    ST_LOAD_INP = 3'd2,
    ST_LOAD_INS = 3'd3,
    ST_RUN      = 3'd4,
    ST_DONE     = 3'd5
  } ld_state_t;

  // Address width wide enough for the deepest memory (at least one bit).
  function automatic int addr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m <= 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/tpu_addr_counter.sv
// Write-address counter used by the command loader for every memory load.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : force the count back to zero (wins over inc)
//   inc        : advance by one, wrapping to zero after limit-1
//   limit      : number of words in the memory being loaded (ADDR_W+1 bits
//                so that a full power-of-two depth is representable)
//   count      : current address
//   last       : count == limit-1
module tpu_addr_counter #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic [ADDR_W:0]   limit,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W:0]   limit_m1_s;

  assign limit_m1_s = limit - {{ADDR_W{1'b0}}, 1'b1};
  assign last       = ({1'b0, count_r} == limit_m1_s);
  assign count      = count_r;

  // Address register: clear has priority, last beat wraps to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {ADDR_W{1'b0}};
    end else if (clear) begin
      count_r <= {ADDR_W{1'b0}};
    end else if (inc) begin
      if (last) begin
        count_r <= {ADDR_W{1'b0}};
      end else begin
        count_r <= count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/tpu_cmd_loader.sv
// Registered command front-end for the TPU.
// Accepts opcodes, streams payload beats into the weight, input and
// instruction memories, issues a one-cycle start to the core and tracks the
// run until the core reports done. All outputs are registered.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   cmd_valid, cmd_opcode : command handshake and opcode
//   data_valid, data_in   : payload beat
//   core_done             : core finished (level or pulse)
//   mem_we_w/inp/ins      : per-memory write strobes
//   mem_addr, mem_wdata   : shared write address and data
//   start                 : one-cycle core start pulse
//   busy                  : high whenever not idle
//   done                  : one-cycle pulse at the end of a run
//   cmd_err               : one-cycle pulse when a command is rejected
module tpu_cmd_loader
  import tpu_pkg::*;
#(
  parameter int  DATA_W    = DEF_DATA_W,
  parameter int  OPC_W     = DEF_OPC_W,
  parameter int  W_DEPTH   = DEF_W_DEPTH,
  parameter int  INP_DEPTH = DEF_INP_DEPTH,
  parameter int  INS_DEPTH = DEF_INS_DEPTH,
  localparam int ADDR_W    = addr_width(W_DEPTH, INP_DEPTH, INS_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [OPC_W-1:0]  cmd_opcode,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              core_done,
  output logic              mem_we_w,
  output logic              mem_we_inp,
  output logic              mem_we_ins,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              cmd_err
);

  localparam int          LIM_W   = ADDR_W + 1;
  localparam logic [ADDR_W:0] W_LIM   = W_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] INP_LIM = INP_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] INS_LIM = INS_DEPTH[ADDR_W:0];

  ld_state_t         state_r, nxt_state_s;
  logic              we_w_s, we_inp_s, we_ins_s;
  logic              start_s, done_s, err_s;
  logic              clr_s, inc_s;
  logic              abort_s, reject_s;
  logic [ADDR_W:0]   limit_s;
  logic [ADDR_W-1:0] count_s;
  logic              last_s;

  logic              mem_we_w_r, mem_we_inp_r, mem_we_ins_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              start_r, busy_r, done_r, cmd_err_r;

  // ABORT is honoured everywhere; in a non-idle state anything but NOP/ABORT is rejected.
  assign abort_s  = cmd_valid && (cmd_opcode == OPC_ABORT);
  assign reject_s = cmd_valid && (cmd_opcode != OPC_NOP) && (cmd_opcode != OPC_ABORT);

  // Depth of the memory currently being loaded.
  always_comb begin
    limit_s = W_LIM;
    case (state_r)
      ST_LOAD_INP: limit_s = INP_LIM;
      ST_LOAD_INS: limit_s = INS_LIM;
      default:     limit_s = W_LIM;
    endcase
  end

  tpu_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk   (clk),
    .reset (reset),
    .clear (clr_s),
    .inc   (inc_s),
    .limit (limit_s),
    .count (count_s),
    .last  (last_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    nxt_state_s = state_r;
    we_w_s      = 1'b0;
    we_inp_s    = 1'b0;
    we_ins_s    = 1'b0;
    start_s     = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    clr_s       = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_opcode)
            OPC_LOAD_W: begin
              nxt_state_s = ST_LOAD_W;
              clr_s       = 1'b1;
            end
            OPC_LOAD_INP: begin
              nxt_state_s = ST_LOAD_INP;
              clr_s       = 1'b1;
            end
            OPC_LOAD_INS: begin
              nxt_state_s = ST_LOAD_INS;
              clr_s       = 1'b1;
            end
            OPC_START: begin
              nxt_state_s = ST_RUN;
              start_s     = 1'b1;
            end
            OPC_NOP, OPC_ABORT: begin
              nxt_state_s = ST_IDLE;
            end
            default: begin
              err_s = 1'b1;
            end
          endcase
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_LOAD_W, ST_LOAD_INP, ST_LOAD_INS: begin
        if (abort_s) begin
          // ABORT beats a simultaneous data beat: nothing is written.
          nxt_state_s = ST_IDLE;
          clr_s       = 1'b1;
        end else begin
          err_s = reject_s;
          if (data_valid) begin
            inc_s    = 1'b1;
            we_w_s   = (state_r == ST_LOAD_W);
            we_inp_s = (state_r == ST_LOAD_INP);
            we_ins_s = (state_r == ST_LOAD_INS);
            if (last_s) begin
              nxt_state_s = ST_IDLE;
            end else begin
              nxt_state_s = state_r;
            end
          end else begin
            nxt_state_s = state_r;
          end
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          nxt_state_s = ST_IDLE;
          clr_s       = 1'b1;
        end else begin
          err_s = reject_s;
          // A core_done seen while the start pulse is still out is stale.
          if (core_done && !start_r) begin
            nxt_state_s = ST_DONE;
            done_s      = 1'b1;
          end else begin
            nxt_state_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        if (abort_s) begin
          clr_s = 1'b1;
        end else begin
          err_s = reject_s;
        end
        nxt_state_s = ST_IDLE;
      end
      default: begin
        nxt_state_s = ST_IDLE;
        clr_s       = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      mem_we_w_r   <= 1'b0;
      mem_we_inp_r <= 1'b0;
      mem_we_ins_r <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cmd_err_r    <= 1'b0;
    end else begin
      state_r      <= nxt_state_s;
      mem_we_w_r   <= we_w_s;
      mem_we_inp_r <= we_inp_s;
      mem_we_ins_r <= we_ins_s;
      if (inc_s) begin
        mem_addr_r  <= count_s;
        mem_wdata_r <= data_in;
      end
      start_r      <= start_s;
      busy_r       <= (nxt_state_s != ST_IDLE);
      done_r       <= done_s;
      cmd_err_r    <= err_s;
    end
  end

  assign mem_we_w   = mem_we_w_r;
  assign mem_we_inp = mem_we_inp_r;
  assign mem_we_ins = mem_we_ins_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign start      = start_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign cmd_err    = cmd_err_r;

  // LIM_W documents the limit bus width shared with the counter.
  logic [LIM_W-1:0] unused_lim_s;
  assign unused_lim_s = limit_s;

endmodule

// File: tb/tb_tpu_cmd_loader.sv
// Self-checking bench for tpu_cmd_loader: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_tpu_cmd_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [2:0] cmd_opcode;
  logic       data_valid;
  logic [7:0] data_in;
  logic       core_done;
  logic       mem_we_w, mem_we_inp, mem_we_ins;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       start, busy, done, cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  // model: mode 0 idle, 1..3 loading memory (1=W,2=INP,3=INS), 4 running, 5 finishing
  int   mode;
  int   idx;
  int   run_age;
  int   depth [4] = '{0, 4, 4, 8};
  logic e_we [4];
  logic e_start, e_done, e_err, e_busy;
  int   e_addr, e_data;

  tpu_cmd_loader dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_opcode (cmd_opcode),
    .data_valid (data_valid),
    .data_in    (data_in),
    .core_done  (core_done),
    .mem_we_w   (mem_we_w),
    .mem_we_inp (mem_we_inp),
    .mem_we_ins (mem_we_ins),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; idx = 0; run_age = 0;
    for (int k = 0; k < 4; k++) e_we[k] = 1'b0;
    e_start = 1'b0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    e_addr = 0; e_data = 0;
  endtask

  // Predict what the outputs show after the coming clock edge.
  task automatic model_step(input logic cv, input int op, input logic dv, input int d, input logic cd);
    for (int k = 0; k < 4; k++) e_we[k] = 1'b0;
    e_start = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (mode == 0) begin
      if (cv) begin
        if (op >= 1 && op <= 3) begin
          mode = op; idx = 0;
        end else if (op == 5) begin
          mode = 4; run_age = 0; e_start = 1'b1;
        end else if (op == 4 || op == 6) begin
          e_err = 1'b1;
        end
      end
    end else if (cv && op == 7) begin
      mode = 0; idx = 0;
    end else begin
      if (cv && op != 0) e_err = 1'b1;
      if (mode >= 1 && mode <= 3) begin
        if (dv) begin
          e_we[mode] = 1'b1;
          e_addr = idx;
          e_data = d;
          idx++;
          if (idx == depth[mode]) begin
            idx = 0; mode = 0;
          end
        end
      end else if (mode == 4) begin
        if (cd && run_age > 0) begin
          mode = 5; e_done = 1'b1;
        end
        run_age++;
      end else begin
        mode = 0;
      end
    end
    e_busy = (mode != 0);
  endtask

  task automatic compare_all();
    check_val("we_w",    mem_we_w,   e_we[1]);
    check_val("we_inp",  mem_we_inp, e_we[2]);
    check_val("we_ins",  mem_we_ins, e_we[3]);
    if (e_we[1] || e_we[2] || e_we[3]) begin
      check_val("addr",  mem_addr,  e_addr);
      check_val("wdata", mem_wdata, e_data);
    end
    check_val("start",   start,   e_start);
    check_val("busy",    busy,    e_busy);
    check_val("done",    done,    e_done);
    check_val("cmd_err", cmd_err, e_err);
  endtask

  task automatic compare_reset();
    check_val("rst_we",    {mem_we_w, mem_we_inp, mem_we_ins}, 32'd0);
    check_val("rst_addr",  mem_addr,  32'd0);
    check_val("rst_wdata", mem_wdata, 32'd0);
    check_val("rst_ctl",   {start, busy, done, cmd_err}, 32'd0);
  endtask

  task automatic cycle(input logic cv, input logic [2:0] op, input logic dv, input logic [7:0] d, input logic cd);
    cmd_valid  = cv;
    cmd_opcode = op;
    data_valid = dv;
    data_in    = d;
    core_done  = cd;
    model_step(cv, int'(op), dv, int'(d), cd);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0; data_valid = 1'b0; core_done = 1'b0;
    reset = 1'b1;
    #1;
    compare_reset();
    @(posedge clk);
    #1;
    compare_reset();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    logic [7:0] pat [4];
    int beats;
    logic       cv, dv, cd;
    logic [2:0] op;
    int         r;

    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = 3'd0;
    data_valid = 1'b0; data_in = 8'd0; core_done = 1'b0;
    model_reset();
    #12;
    compare_reset();
    reset = 1'b0;

    // reset mid LOAD_W after two beats, then a full load restarts at address 0
    cycle(1'b1, 3'b001, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 3'b000, 1'b1, 8'hA1, 1'b0);
    cycle(1'b0, 3'b000, 1'b1, 8'hA2, 1'b0);
    apply_reset();

    // LOAD_W with 0x11..0x44
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    cycle(1'b1, 3'b001, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 3'b000, 1'b1, pat[k], 1'b0);
    idle_cycles(2);

    // LOAD_INS with gaps in data_valid
    cycle(1'b1, 3'b011, 1'b0, 8'h00, 1'b0);
    beats = 0;
    for (int k = 0; beats < 8 && k < 64; k++) begin
      dv = ((k % 3) == 0);
      if (dv) beats++;
      cycle(1'b0, 3'b000, dv, 8'(8'h80 + k), 1'b0);
    end
    idle_cycles(2);

    // START, core_done after 10 cycles
    cycle(1'b1, 3'b101, 1'b0, 8'h00, 1'b0);
    idle_cycles(10);
    cycle(1'b0, 3'b000, 1'b0, 8'h00, 1'b1);
    idle_cycles(2);

    // core_done coincident with the start pulse is ignored
    cycle(1'b1, 3'b101, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 3'b000, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 3'b000, 1'b0, 8'h00, 1'b1);
    idle_cycles(2);

    // LOAD_INP, two beats, ABORT together with a beat
    cycle(1'b1, 3'b010, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 3'b000, 1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 3'b000, 1'b1, 8'h5B, 1'b0);
    cycle(1'b1, 3'b111, 1'b1, 8'h5C, 1'b0);
    idle_cycles(2);

    // LOAD_W during RUN, illegal opcode in IDLE
    cycle(1'b1, 3'b101, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 3'b000, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 3'b001, 1'b1, 8'h77, 1'b0);
    cycle(1'b0, 3'b000, 1'b0, 8'h00, 1'b1);
    idle_cycles(2);
    cycle(1'b1, 3'b100, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 3'b110, 1'b1, 8'h00, 1'b0);
    idle_cycles(1);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
      end else begin
        cv = ($urandom_range(0, 99) < 25);
        r  = $urandom_range(0, 15);
        case (r)
          0, 1, 2:  op = 3'b001;
          3, 4, 5:  op = 3'b010;
          6, 7, 8:  op = 3'b011;
          9, 10:    op = 3'b101;
          11:       op = 3'b111;
          12:       op = 3'b100;
          13:       op = 3'b110;
          default:  op = 3'b000;
        endcase
        dv = ($urandom_range(0, 99) < 55);
        cd = ($urandom_range(0, 99) < 15);
        cycle(cv, op, dv, 8'($urandom), cd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
